// File: rtl/countdown_timer_100ms.sv
// min:sec.tenth countdown driven by an asynchronous 100 ms tick stream.
// Start/pause control, a one-cycle done pulse on reaching 0:00.0, and a held expired level.
module countdown_timer_100ms #(
  parameter int MAX_MIN     = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic [3:0] load_tenth,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [3:0] tenth,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam logic [5:0] MAX_MIN_W = MAX_MIN[5:0];

  state_t                 state;
  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   tick_dly;
  logic                   tick_en;
  logic [5:0]             dec_min;
  logic [5:0]             dec_sec;
  logic [3:0]             dec_tenth;
  logic                   dec_zero;
  logic                   val_zero;

  function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [3:0] sat4(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Synchronizer plus one edge flop: one tick_en per rising edge of tick_100ms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_sync <= '0;
      tick_dly  <= 1'b0;
    end else begin
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_100ms};
      tick_dly  <= tick_sync[SYNC_STAGES-1];
    end
  end

  assign tick_en  = tick_sync[SYNC_STAGES-1] & ~tick_dly;
  assign val_zero = (min == 6'd0) && (sec == 6'd0) && (tenth == 4'd0);

  // Mixed-radix decrement; holds at 0:00.0 rather than wrapping
  always_comb begin
    dec_min   = min;
    dec_sec   = sec;
    dec_tenth = tenth;
    if (tenth != 4'd0) begin
      dec_tenth = tenth - 4'd1;
    end else if (sec != 6'd0) begin
      dec_tenth = 4'd9;
      dec_sec   = sec - 6'd1;
    end else if (min != 6'd0) begin
      dec_tenth = 4'd9;
      dec_sec   = 6'd59;
      dec_min   = min - 6'd1;
    end
    dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0) && (dec_tenth == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      min     <= 6'd0;
      sec     <= 6'd0;
      tenth   <= 4'd0;
      running <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            min   <= sat6(load_min, MAX_MIN_W);
            sec   <= sat6(load_sec, 6'd59);
            tenth <= sat4(load_tenth, 4'd9);
          end else if (!pause && start && !val_zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          // A tick coinciding with pause is dropped
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
            paused  <= 1'b1;
          end else if (tick_en) begin
            min   <= dec_min;
            sec   <= dec_sec;
            tenth <= dec_tenth;
            if (dec_zero) begin
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
              done    <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (load) begin
            min    <= sat6(load_min, MAX_MIN_W);
            sec    <= sat6(load_sec, 6'd59);
            tenth  <= sat4(load_tenth, 4'd9);
            state  <= IDLE;
            paused <= 1'b0;
          end else if (!pause && start) begin
            state   <= RUN;
            paused  <= 1'b0;
            running <= 1'b1;
          end
        end
        default: begin
          if (load) begin
            min     <= sat6(load_min, MAX_MIN_W);
            sec     <= sat6(load_sec, 6'd59);
            tenth   <= sat4(load_tenth, 4'd9);
            state   <= IDLE;
            expired <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_100ms.sv
// Scoreboard bench for countdown_timer_100ms: a total-tenths model predicts value,
// state and done count per tick; predictions are queued and popped after the tick settles.
module tb_countdown_timer_100ms;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_100ms = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [3:0] load_tenth = '0;
  logic [5:0] min, sec;
  logic [3:0] tenth;
  logic       running, paused, done, expired;

  typedef struct {
    int mn;
    int sc;
    int tn;
    int st;
    int dn;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   m_min = 0, m_sec = 0, m_ten = 0, m_st = 0;  // m_st: 0 idle, 1 run, 2 paused, 3 expired

  always #5 clk = ~clk;

  countdown_timer_100ms #(.MAX_MIN(59), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .tick_100ms(tick_100ms), .load(load),
    .load_min(load_min), .load_sec(load_sec), .load_tenth(load_tenth),
    .start(start), .pause(pause), .min(min), .sec(sec), .tenth(tenth),
    .running(running), .paused(paused), .done(done), .expired(expired)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_now(input int dn);
    exp_t e;
    e.mn = m_min; e.sc = m_sec; e.tn = m_ten; e.st = m_st; e.dn = dn;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check_val({tag, ".min"},     32'(min),     32'(e.mn));
    check_val({tag, ".sec"},     32'(sec),     32'(e.sc));
    check_val({tag, ".tenth"},   32'(tenth),   32'(e.tn));
    check_val({tag, ".running"}, 32'(running), 32'(e.st == 1));
    check_val({tag, ".paused"},  32'(paused),  32'(e.st == 2));
    check_val({tag, ".expired"}, 32'(expired), 32'(e.st == 3));
  endtask

  task automatic do_load(input int m, input int s, input int t);
    load_min = 6'(m); load_sec = 6'(s); load_tenth = 4'(t); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (m_st != 1) begin
      m_min = (m > 59) ? 59 : m;
      m_sec = (s > 59) ? 59 : s;
      m_ten = (t > 9) ? 9 : t;
      m_st  = 0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_st == 0 && (m_min * 600 + m_sec * 10 + m_ten) != 0) m_st = 1;
    else if (m_st == 2) m_st = 1;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    if (m_st == 1) m_st = 2;
  endtask

  // One tick of `hold` clocks; with_pause lines pause up with the resulting tick_en
  task automatic do_tick(input string tag, input int hold, input bit with_pause);
    int   tot;
    int   dn;
    int   base;
    exp_t e;
    dn = 0;
    if (m_st == 1) begin
      if (with_pause) begin
        m_st = 2;
      end else begin
        tot = m_min * 600 + m_sec * 10 + m_ten - 1;
        m_min = tot / 600; m_sec = (tot % 600) / 10; m_ten = tot % 10;
        if (tot == 0) begin m_st = 3; dn = 1; end
      end
    end
    sbq.push_back(model_now(dn));
    base = done_cnt;
    tick_100ms = 1'b1;
    if (with_pause) begin
      repeat (SYNC) @(negedge clk);
      pause = 1'b1;
      @(negedge clk);
      pause = 1'b0;
    end else begin
      repeat (hold) @(negedge clk);
    end
    tick_100ms = 1'b0;
    repeat (SYNC + 4) @(negedge clk);
    if (sbq.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check_outputs(tag, e);
      check_val({tag, ".done_cnt"}, 32'(done_cnt - base), 32'(e.dn));
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("reset", model_now(0));
    check_val("reset.done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Count 0:01.2 down to zero
    do_load(0, 1, 2);
    do_start();
    check_outputs("run012", model_now(0));
    for (int i = 0; i < 12; i++) do_tick($sformatf("cnt%0d", i), 3, 1'b0);

    // Borrow chains
    do_load(2, 0, 0);
    do_start();
    do_tick("borrow_min", 3, 1'b0);
    do_pause();
    do_load(1, 0, 0);
    do_start();
    do_tick("borrow_sec", 3, 1'b0);

    // Load saturation
    do_pause();
    do_load(63, 60, 15);
    check_outputs("saturate", model_now(0));

    // Pause colliding with a tick, ticks while paused, resume
    do_load(0, 5, 0);
    do_start();
    do_tick("pause_tick", 3, 1'b1);
    for (int i = 0; i < 3; i++) do_tick($sformatf("paused%0d", i), 3, 1'b0);
    do_start();
    do_tick("resume", 3, 1'b0);

    // Load ignored while running
    do_load(0, 7, 7);
    check_outputs("load_in_run", model_now(0));

    // Long tick level gives one decrement
    do_tick("long_tick", 50, 1'b0);

    // Start at zero stays idle
    do_pause();
    do_load(0, 0, 0);
    do_start();
    check_outputs("start_zero", model_now(0));
    do_tick("zero_tick", 3, 1'b0);

    // Asynchronous reset mid-count
    do_load(0, 3, 4);
    do_start();
    check_outputs("pre_rst", model_now(0));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    m_min = 0; m_sec = 0; m_ten = 0; m_st = 0;
    check_outputs("async_rst", model_now(0));
    check_val("async_rst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_tick("post_rst0", 3, 1'b0);
    do_tick("post_rst1", 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
